// File: rtl/johnson_decoder.sv
// -----------------------------------------------------------------------------
// johnson_decoder
//
// Registered decoder and sequence checker for a Johnson (twisted-ring) count.
// Each sample of data_i is converted to a binary count 0..2*WIDTH-1, checked
// for being a legal Johnson code, and classified against the previous legal
// count as INC (+1 modulo 2*WIDTH), HOLD or SKIP.  A three-state lock FSM
// reports when the incoming sequence can be trusted.
//
// Parameters
//   WIDTH     Johnson register width; the sequence has 2*WIDTH states.
//   LOCK_CNT  consecutive INC steps needed to go from LOCKING to LOCKED (1..15).
//   CW        count width, $clog2(2*WIDTH).
//
// Ports
//   clk_i      in   clock, rising edge
//   rst_ni     in   asynchronous active-low reset
//   valid_i    in   data_i is sampled this cycle
//   data_i     in   [WIDTH-1:0] Johnson code
//   err_clr_i  in   synchronous clear of err_cnt_o (wins over a new error)
//   valid_o    out  one-cycle pulse, count_o updated
//   count_o    out  [CW-1:0] decoded count of the last legal sample
//   illegal_o  out  one-cycle pulse, last sample was not a Johnson code
//   skip_o     out  one-cycle pulse, legal code that was neither HOLD nor INC
//   locked_o   out  high while the FSM is LOCKED
//   err_cnt_o  out  [7:0] saturating count of illegal and skip events
//   state_o    out  [1:0] current FSM state (0 UNLOCKED, 1 LOCKING, 2 LOCKED)
//
// Build option
//   JOHNSON_ERR_CNT_EN  when defined, the saturating error counter and its
//                       clear are built; otherwise err_cnt_o is tied to 0 and
//                       err_clr_i is ignored.
//
// Handshake: there is no back-pressure.  A sample is consumed on every rising
// edge where valid_i is high; results appear one edge later as single-cycle
// pulses on valid_o / illegal_o / skip_o, and all pulses are low for a cycle
// in which no sample was taken.
// -----------------------------------------------------------------------------
module johnson_decoder #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    localparam int CW      = $clog2(2 * WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             err_clr_i,
    output logic             valid_o,
    output logic [CW-1:0]    count_o,
    output logic             illegal_o,
    output logic             skip_o,
    output logic             locked_o,
    output logic [7:0]       err_cnt_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_COUNT = CW'(2 * WIDTH - 1);
    localparam logic [3:0]    LOCK_TGT   = 4'(LOCK_CNT);

    // Population count; result never exceeds WIDTH, which fits in CW bits.
    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [3:0]    gcnt_q, gcnt_d;
    // count_q doubles as the "previous legal count" used for step checks:
    // both are loaded on exactly the same events and reset to the same value.
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          illegal_q, illegal_d;
    logic          skip_q, skip_d;

    // -------------------------------------------------------------------------
    // Code decode
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] data_inv;
    logic             dec_legal;
    logic [CW-1:0]    dec_count;

    assign data_inv = ~data_i;

    always_comb begin
        dec_legal = 1'b0;
        dec_count = '0;
        if (!data_i[WIDTH-1]) begin
            // Filling phase: ones must be contiguous from the LSB, so adding
            // one clears them all and the AND is zero.
            dec_legal = ((data_i & (data_i + 1'b1)) == '0);
            dec_count = popcount(data_i);
        end else begin
            // Draining phase: the zeros are contiguous from the LSB instead.
            dec_legal = ((data_inv & (data_inv + 1'b1)) == '0);
            dec_count = CW'(WIDTH) + popcount(data_inv);
        end
    end

    // -------------------------------------------------------------------------
    // Step classification against the previous legal count
    // -------------------------------------------------------------------------
    logic [CW-1:0] prev_plus1;
    logic          step_inc;
    logic          step_hold;

    // Modulo 2*WIDTH increment; 2*WIDTH need not be a power of two.
    assign prev_plus1 = (count_q == LAST_COUNT) ? '0 : count_q + 1'b1;
    assign step_inc   = (dec_count == prev_plus1);
    assign step_hold  = (dec_count == count_q);

    // -------------------------------------------------------------------------
    // Lock FSM: next state and pulse outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        count_d   = count_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        skip_d    = 1'b0;

        if (valid_i) begin
            if (!dec_legal) begin
                // Count and previous value are deliberately left untouched.
                illegal_d = 1'b1;
                state_d   = ST_UNLOCKED;
                gcnt_d    = '0;
            end else begin
                valid_d = 1'b1;
                count_d = dec_count;
                unique case (state_q)
                    ST_UNLOCKED: begin
                        // First trusted reference point; nothing to compare.
                        state_d = ST_LOCKING;
                        gcnt_d  = '0;
                    end
                    ST_LOCKING: begin
                        if (step_inc) begin
                            gcnt_d = gcnt_q + 1'b1;
                            if (gcnt_d == LOCK_TGT) begin
                                state_d = ST_LOCKED;
                            end
                        end else if (!step_hold) begin
                            gcnt_d = '0;
                            skip_d = 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!step_inc && !step_hold) begin
                            skip_d  = 1'b1;
                            gcnt_d  = '0;
                            state_d = ST_LOCKING;
                        end
                    end
                    default: begin
                        state_d = ST_UNLOCKED;
                        gcnt_d  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_UNLOCKED;
            gcnt_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gcnt_q    <= gcnt_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            skip_q    <= skip_d;
        end
    end

    assign valid_o   = valid_q;
    assign count_o   = count_q;
    assign illegal_o = illegal_q;
    assign skip_o    = skip_q;
    // Decoded from the state register so it falls with an asynchronous reset.
    assign locked_o  = (state_q == ST_LOCKED);
    assign state_o   = state_q;

    // -------------------------------------------------------------------------
    // Error counter
    // -------------------------------------------------------------------------
`ifdef JOHNSON_ERR_CNT_EN
    logic [7:0] err_q;

    // Counts the same event that is registered onto illegal_o/skip_o, so the
    // new value is visible in the same cycle as the pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else if (err_clr_i) begin
            err_q <= '0;
        end else if ((illegal_d || skip_d) && (err_q != 8'hFF)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_cnt_o = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr_i;
    assign err_cnt_o      = '0;
`endif

endmodule
